// File: rtl/ev22_pkg.sv
// Shared EV22 register-bank constants and the write-address legality check.
// The write-back decoder uses the same is_writable() function.
package ev22_pkg;

    localparam int DATA_W = 16;
    localparam int SEL_W  = 6;
    localparam int NUM_GP = 28;

    localparam logic [SEL_W-1:0] ADDR_PI0  = 6'd28;
    localparam logic [SEL_W-1:0] ADDR_PI1  = 6'd29;
    localparam logic [SEL_W-1:0] ADDR_PO0  = 6'd30;
    localparam logic [SEL_W-1:0] ADDR_PO1  = 6'd31;
    localparam logic [SEL_W-1:0] ADDR_R32  = 6'd32;
    localparam logic [SEL_W-1:0] ADDR_R33  = 6'd33;
    localparam logic [SEL_W-1:0] ADDR_WREG = 6'd34;

    // Input ports are read-only, and nothing above the Working Register is mapped.
    function automatic logic is_writable(input logic [SEL_W-1:0] sel);
        return (sel <= ADDR_WREG) && (sel != ADDR_PI0) && (sel != ADDR_PI1);
    endfunction

endpackage

// File: rtl/port_sync.sv
// Input-port capture for PI0/PI1: two flops when INPUT_SYNC_EN is defined,
// a single capture flop otherwise (only for ports known synchronous to clk).
module port_sync
    import ev22_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [DATA_W-1:0] port_in,
    output logic [DATA_W-1:0] port_q
);

`ifdef INPUT_SYNC_EN
    logic [DATA_W-1:0] meta_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            meta_q <= '0;
            port_q <= '0;
        end else begin
            meta_q <= port_in;
            port_q <= meta_q;
        end
    end
`else
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            port_q <= '0;
        end else begin
            port_q <= port_in;
        end
    end
`endif

endmodule

// File: rtl/register_bank_wb.sv
// EV22 register bank and write-back stage feeding the operand-select mux.
// Build option: INPUT_SYNC_EN selects a 2-flop synchronizer on Port_In_0/1.
module register_bank_wb
    import ev22_pkg::*;
(
    input  logic              clk,
    input  logic              reset_n,
    input  logic [SEL_W-1:0]  Sel_C,
    input  logic              Write_En,
    input  logic [DATA_W-1:0] Data_C,
    input  logic              Clear_Err,
    input  logic [DATA_W-1:0] Port_In_0,
    input  logic [DATA_W-1:0] Port_In_1,
    output logic [DATA_W-1:0] Port_Out_0,
    output logic [DATA_W-1:0] Port_Out_1,
    output logic [DATA_W-1:0] r0,
    output logic [DATA_W-1:0] r1,
    output logic [DATA_W-1:0] r2,
    output logic [DATA_W-1:0] r3,
    output logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] r5,
    output logic [DATA_W-1:0] r6,
    output logic [DATA_W-1:0] r7,
    output logic [DATA_W-1:0] r8,
    output logic [DATA_W-1:0] r9,
    output logic [DATA_W-1:0] r10,
    output logic [DATA_W-1:0] r11,
    output logic [DATA_W-1:0] r12,
    output logic [DATA_W-1:0] r13,
    output logic [DATA_W-1:0] r14,
    output logic [DATA_W-1:0] r15,
    output logic [DATA_W-1:0] r16,
    output logic [DATA_W-1:0] r17,
    output logic [DATA_W-1:0] r18,
    output logic [DATA_W-1:0] r19,
    output logic [DATA_W-1:0] r20,
    output logic [DATA_W-1:0] r21,
    output logic [DATA_W-1:0] r22,
    output logic [DATA_W-1:0] r23,
    output logic [DATA_W-1:0] r24,
    output logic [DATA_W-1:0] r25,
    output logic [DATA_W-1:0] r26,
    output logic [DATA_W-1:0] r27,
    output logic [DATA_W-1:0] r28,
    output logic [DATA_W-1:0] r29,
    output logic [DATA_W-1:0] r32,
    output logic [DATA_W-1:0] r33,
    output logic [DATA_W-1:0] Working_Register,
    output logic              Illegal_Write
);

    logic [DATA_W-1:0] gp_q [NUM_GP];
    logic [DATA_W-1:0] po0_q, po1_q, r32_q, r33_q, wreg_q;
    logic              illegal_q;
    logic              wr_ok;
    logic              wr_bad;

    assign wr_ok  = Write_En &&  is_writable(Sel_C);
    assign wr_bad = Write_En && !is_writable(Sel_C);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_GP; i++) gp_q[i] <= '0;
            po0_q  <= '0;
            po1_q  <= '0;
            r32_q  <= '0;
            r33_q  <= '0;
            wreg_q <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NUM_GP; i++) begin
                if (Sel_C == SEL_W'(i)) gp_q[i] <= Data_C;
            end
            case (Sel_C)
                ADDR_PO0:  po0_q  <= Data_C;
                ADDR_PO1:  po1_q  <= Data_C;
                ADDR_R32:  r32_q  <= Data_C;
                ADDR_R33:  r33_q  <= Data_C;
                ADDR_WREG: wreg_q <= Data_C;
                default:   ;
            endcase
        end
    end

    // A new illegal write takes priority over a clear in the same cycle.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            illegal_q <= 1'b0;
        end else if (wr_bad) begin
            illegal_q <= 1'b1;
        end else if (Clear_Err) begin
            illegal_q <= 1'b0;
        end
    end

    port_sync u_sync_pi0 (.clk(clk), .reset_n(reset_n), .port_in(Port_In_0), .port_q(r28));
    port_sync u_sync_pi1 (.clk(clk), .reset_n(reset_n), .port_in(Port_In_1), .port_q(r29));

    assign r0  = gp_q[0];
    assign r1  = gp_q[1];
    assign r2  = gp_q[2];
    assign r3  = gp_q[3];
    assign r4  = gp_q[4];
    assign r5  = gp_q[5];
    assign r6  = gp_q[6];
    assign r7  = gp_q[7];
    assign r8  = gp_q[8];
    assign r9  = gp_q[9];
    assign r10 = gp_q[10];
    assign r11 = gp_q[11];
    assign r12 = gp_q[12];
    assign r13 = gp_q[13];
    assign r14 = gp_q[14];
    assign r15 = gp_q[15];
    assign r16 = gp_q[16];
    assign r17 = gp_q[17];
    assign r18 = gp_q[18];
    assign r19 = gp_q[19];
    assign r20 = gp_q[20];
    assign r21 = gp_q[21];
    assign r22 = gp_q[22];
    assign r23 = gp_q[23];
    assign r24 = gp_q[24];
    assign r25 = gp_q[25];
    assign r26 = gp_q[26];
    assign r27 = gp_q[27];

    assign Port_Out_0       = po0_q;
    assign Port_Out_1       = po1_q;
    assign r32              = r32_q;
    assign r33              = r33_q;
    assign Working_Register = wreg_q;
    assign Illegal_Write    = illegal_q;

endmodule

// File: tb/tb_register_bank_wb.sv
// Self-checking bench for register_bank_wb: vector table, hand-written corner
// sequences, randomized writes against a bank model. Honours INPUT_SYNC_EN.
module tb_register_bank_wb;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [5:0]  Sel_C = '0;
    logic        Write_En = 1'b0;
    logic [15:0] Data_C = '0;
    logic        Clear_Err = 1'b0;
    logic [15:0] Port_In_0 = '0;
    logic [15:0] Port_In_1 = '0;
    logic        Illegal_Write;
    logic [15:0] dut_out [0:34];

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] exp_q [$];
    logic        ill_q [$];

    // Bank model: index = Sel_C address; 28/29 mirror the input-port capture.
    logic [15:0] m_reg [0:34];
    logic [15:0] m_st0, m_st1;
    logic        m_ill;

`ifdef INPUT_SYNC_EN
    localparam int PI_LAT = 2;
`else
    localparam int PI_LAT = 1;
`endif

    register_bank_wb dut (
        .clk(clk), .reset_n(reset_n), .Sel_C(Sel_C), .Write_En(Write_En),
        .Data_C(Data_C), .Clear_Err(Clear_Err),
        .Port_In_0(Port_In_0), .Port_In_1(Port_In_1),
        .Port_Out_0(dut_out[30]), .Port_Out_1(dut_out[31]),
        .r0(dut_out[0]),   .r1(dut_out[1]),   .r2(dut_out[2]),   .r3(dut_out[3]),
        .r4(dut_out[4]),   .r5(dut_out[5]),   .r6(dut_out[6]),   .r7(dut_out[7]),
        .r8(dut_out[8]),   .r9(dut_out[9]),   .r10(dut_out[10]), .r11(dut_out[11]),
        .r12(dut_out[12]), .r13(dut_out[13]), .r14(dut_out[14]), .r15(dut_out[15]),
        .r16(dut_out[16]), .r17(dut_out[17]), .r18(dut_out[18]), .r19(dut_out[19]),
        .r20(dut_out[20]), .r21(dut_out[21]), .r22(dut_out[22]), .r23(dut_out[23]),
        .r24(dut_out[24]), .r25(dut_out[25]), .r26(dut_out[26]), .r27(dut_out[27]),
        .r28(dut_out[28]), .r29(dut_out[29]), .r32(dut_out[32]), .r33(dut_out[33]),
        .Working_Register(dut_out[34]), .Illegal_Write(Illegal_Write)
    );

    // Clock / reset
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [5:0]  sel;
        logic [15:0] data;
        logic        clr;
        logic [5:0]  chk;
        logic [15:0] exp_val;
        logic        exp_ill;
    } vec_t;

    vec_t tbl [14];

    function automatic logic legal(input logic [5:0] sel);
        return (sel <= 6'd34) && (sel != 6'd28) && (sel != 6'd29);
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%h expected=0x%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 35; i++) m_reg[i] = '0;
        m_st0 = '0;
        m_st1 = '0;
        m_ill = 1'b0;
    endtask

    task automatic model_step(input logic we, input logic [5:0] sel,
                              input logic [15:0] data, input logic clr);
        if (we && legal(sel)) m_reg[sel] = data;
        if (we && !legal(sel)) m_ill = 1'b1;
        else if (clr) m_ill = 1'b0;
`ifdef INPUT_SYNC_EN
        m_reg[28] = m_st0;
        m_reg[29] = m_st1;
        m_st0 = Port_In_0;
        m_st1 = Port_In_1;
`else
        m_reg[28] = Port_In_0;
        m_reg[29] = Port_In_1;
`endif
    endtask

    // One counted comparison of every output against the model.
    task automatic check_bank(input string name);
        int bad;
        bad = -1;
        for (int i = 0; i < 35; i++) begin
            if (i != 35 && dut_out[i] !== m_reg[i] && bad < 0) bad = i;
        end
        n_checks++;
        if (bad >= 0) begin
            n_fail++;
            $display("FAIL %s reg%0d actual=0x%h expected=0x%h", name, bad, dut_out[bad], m_reg[bad]);
        end
        check({name, "_ill"}, {15'd0, Illegal_Write}, {15'd0, m_ill});
    endtask

    // Driver: called just after a falling edge; returns at the next falling edge.
    task automatic step(input logic we, input logic [5:0] sel,
                        input logic [15:0] data, input logic clr);
        Write_En  = we;
        Sel_C     = sel;
        Data_C    = data;
        Clear_Err = clr;
        model_step(we, sel, data, clr);
        @(posedge clk);
        @(negedge clk);
        Write_En  = 1'b0;
        Clear_Err = 1'b0;
    endtask

    initial begin
        logic [15:0] ev;
        logic        ei;
        logic [5:0]  rs;

        tbl[0]  = '{1'b1, 6'd5,  16'hBEEF, 1'b0, 6'd5,  16'hBEEF, 1'b0};
        tbl[1]  = '{1'b1, 6'd30, 16'h00A5, 1'b0, 6'd30, 16'h00A5, 1'b0};
        tbl[2]  = '{1'b1, 6'd34, 16'h7FFF, 1'b0, 6'd34, 16'h7FFF, 1'b0};
        tbl[3]  = '{1'b1, 6'd0,  16'h1111, 1'b0, 6'd0,  16'h1111, 1'b0};
        tbl[4]  = '{1'b1, 6'd27, 16'hFFFF, 1'b0, 6'd27, 16'hFFFF, 1'b0};
        tbl[5]  = '{1'b1, 6'd33, 16'h8001, 1'b0, 6'd33, 16'h8001, 1'b0};
        tbl[6]  = '{1'b1, 6'd32, 16'h0032, 1'b0, 6'd32, 16'h0032, 1'b0};
        tbl[7]  = '{1'b1, 6'd31, 16'h5A5A, 1'b0, 6'd31, 16'h5A5A, 1'b0};
        tbl[8]  = '{1'b0, 6'd5,  16'h0000, 1'b0, 6'd5,  16'hBEEF, 1'b0};
        tbl[9]  = '{1'b1, 6'd28, 16'hDEAD, 1'b0, 6'd28, 16'h0000, 1'b1};
        tbl[10] = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd28, 16'h0000, 1'b0};
        tbl[11] = '{1'b1, 6'd63, 16'h1234, 1'b0, 6'd5,  16'hBEEF, 1'b1};
        tbl[12] = '{1'b1, 6'd35, 16'h4321, 1'b1, 6'd34, 16'h7FFF, 1'b1};
        tbl[13] = '{1'b0, 6'd0,  16'h0000, 1'b1, 6'd34, 16'h7FFF, 1'b0};

        // Reset state
        model_reset();
        repeat (3) @(negedge clk);
        check_bank("reset_state");
        reset_n = 1'b1;

        // Vector table
        for (int i = 0; i < 14; i++) begin
            exp_q.push_back(tbl[i].exp_val);
            ill_q.push_back(tbl[i].exp_ill);
            step(tbl[i].we, tbl[i].sel, tbl[i].data, tbl[i].clr);
            ev = exp_q.pop_front();
            ei = ill_q.pop_front();
            check($sformatf("vec%0d_r%0d", i, tbl[i].chk), dut_out[tbl[i].chk], ev);
            check($sformatf("vec%0d_ill", i), {15'd0, Illegal_Write}, {15'd0, ei});
            check_bank($sformatf("vec%0d_bank", i));
        end

        // Input-port step and latency, then a write to read-only r29
        Port_In_1 = 16'h5A5A;
        step(1'b0, 6'd0, 16'h0, 1'b0);
        check("pi1_edge1", dut_out[29], (PI_LAT == 1) ? 16'h5A5A : 16'h0000);
        step(1'b0, 6'd0, 16'h0, 1'b0);
        check("pi1_edge2", dut_out[29], 16'h5A5A);
        step(1'b1, 6'd29, 16'h0000, 1'b0);
        check("pi1_ro_write", dut_out[29], 16'h5A5A);
        check("pi1_ro_ill", {15'd0, Illegal_Write}, 16'h0001);
        check_bank("pi1_bank");
        step(1'b0, 6'd0, 16'h0, 1'b1);
        check("pi1_clr", {15'd0, Illegal_Write}, 16'h0000);

        // Back-to-back writes to r7
        step(1'b1, 6'd7, 16'h0001, 1'b0);
        check("b2b_first", dut_out[7], 16'h0001);
        step(1'b1, 6'd7, 16'h0002, 1'b0);
        check("b2b_second", dut_out[7], 16'h0002);
        check_bank("b2b_bank");

        // Randomized writes, illegal addresses and clears
        for (int i = 0; i < 60; i++) begin
            rs = 6'($urandom_range(0, 63));
            Port_In_0 = 16'($urandom_range(0, 65535));
            Port_In_1 = 16'($urandom_range(0, 65535));
            step(1'($urandom_range(0, 1)), rs, 16'($urandom_range(0, 65535)),
                 1'($urandom_range(0, 3) == 0));
            check_bank($sformatf("rand%0d", i));
        end

        // Asynchronous reset mid-run after loading r5
        Port_In_0 = '0;
        Port_In_1 = '0;
        step(1'b1, 6'd5, 16'h1234, 1'b0);
        check("pre_reset_r5", dut_out[5], 16'h1234);
        #2;
        reset_n = 1'b0;
        #1;
        model_reset();
        check_bank("async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        step(1'b1, 6'd6, 16'hA5A5, 1'b0);
        check("post_reset_r6", dut_out[6], 16'hA5A5);
        check_bank("post_reset_bank");

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
